// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory stage.
// Holds the FSM state, funct3 access sizes and WB select codes.
package mem_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // Unknown funct3 encodings fall through to word size.
   function automatic logic f3_aligned(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      case (f3)
         F3_B, F3_BU: return 1'b1;
         F3_H, F3_HU: return ~off[0];
         default:     return off == 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Store lane/byte-enable generation and load lane extract/extend.
// Purely combinational.
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  i_f3,
   input  logic [1:0]  i_off,
   input  logic        i_we,
   input  logic [31:0] i_sdata,
   input  logic [31:0] i_rdata,
   output logic        o_aligned,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_ldata
);

   logic [31:0] w_lane;

   always_comb begin
      o_aligned = f3_aligned(i_f3, i_off);
      w_lane    = i_rdata >> {i_off, 3'b000};
      o_wdata   = i_sdata;
      o_be      = 4'b1111;
      o_ldata   = i_rdata;
      case (i_f3)
         F3_B, F3_BU: begin
            if (i_f3 == F3_B)
               o_ldata = {{24{w_lane[7]}}, w_lane[7:0]};
            else
               o_ldata = {24'd0, w_lane[7:0]};
            if (i_we) begin
               o_wdata = {4{i_sdata[7:0]}};
               o_be    = 4'b0001 << i_off;
            end
         end
         F3_H, F3_HU: begin
            if (i_f3 == F3_H)
               o_ldata = {{16{w_lane[15]}}, w_lane[15:0]};
            else
               o_ldata = {16'd0, w_lane[15:0]};
            if (i_we) begin
               o_wdata = {2{i_sdata[15:0]}};
               o_be    = 4'b0011 << i_off;
            end
         end
         default: begin
            o_ldata = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-cache handshake FSM with timeout, misalign
// detection and the MEM/WB pipeline register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] alu_mem_i,
   input  logic [31:0] rs2_mem_i,
   input  logic [31:0] pc4_mem_i,
   input  logic        MemRW_mem_i,
   input  logic        is_ls_mem_i,
   input  logic [1:0]  WBSel_mem_i,
   input  logic        RegWEn_mem_i,
   input  logic [4:0]  rsW_mem_i,
   input  logic [31:0] inst_mem_i,
   input  logic        enable_i,
   input  logic        reset_i,
   output logic        dc_req_o,
   output logic        dc_we_o,
   output logic [31:0] dc_addr_o,
   output logic [31:0] dc_wdata_o,
   output logic [3:0]  dc_be_o,
   input  logic        dc_ack_i,
   input  logic [31:0] dc_rdata_i,
   output logic        stall_o,
   output logic [31:0] alu_wb_o,
   output logic [31:0] mem_wb_o,
   output logic [31:0] pc4_wb_o,
   output logic [1:0]  WBSel_wb_o,
   output logic        RegWEn_wb_o,
   output logic [4:0]  rsW_wb_o,
   output logic [31:0] inst_wb_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_e        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_f3;
   logic [1:0]    r_off;
   logic          r_dc_we;
   logic [31:0]   r_dc_addr;
   logic [31:0]   r_dc_wdata;
   logic [3:0]    r_dc_be;
   logic          r_mis;
   logic          r_to;
   logic [31:0]   r_alu_wb;
   logic [31:0]   r_mem_wb;
   logic [31:0]   r_pc4_wb;
   logic [1:0]    r_wbsel_wb;
   logic          r_regwen_wb;
   logic [4:0]    r_rsw_wb;
   logic [31:0]   r_inst_wb;

   logic          w_idle;
   logic          w_wait;
   logic [2:0]    w_f3;
   logic [1:0]    w_off;
   logic          w_aligned;
   logic [31:0]   w_wdata;
   logic [3:0]    w_be;
   logic [31:0]   w_ldata;
   logic          w_go;
   logic          w_mis;
   logic          w_to;
   logic          w_stall;
   logic          w_adv;
   logic          w_ld_done;

   assign w_idle = (r_state == S_IDLE);
   assign w_wait = (r_state == S_WAIT);

   // In WAIT the captured size/offset drive load extraction.
   assign w_f3  = w_wait ? r_f3  : inst_mem_i[14:12];
   assign w_off = w_wait ? r_off : alu_mem_i[1:0];

   lsu_align u_align (
      .i_f3      (w_f3),
      .i_off     (w_off),
      .i_we      (MemRW_mem_i),
      .i_sdata   (rs2_mem_i),
      .i_rdata   (dc_rdata_i),
      .o_aligned (w_aligned),
      .o_wdata   (w_wdata),
      .o_be      (w_be),
      .o_ldata   (w_ldata)
   );

   assign w_go      = w_idle & is_ls_mem_i & w_aligned;
   assign w_mis     = w_idle & is_ls_mem_i & ~w_aligned;
   assign w_to      = w_wait & ~dc_ack_i
                    & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_stall   = w_go | (w_wait & ~dc_ack_i & ~w_to);
   assign w_adv     = enable_i & ~w_stall;
   assign w_ld_done = w_wait & dc_ack_i & ~r_dc_we;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_f3        <= '0;
         r_off       <= '0;
         r_dc_we     <= 1'b0;
         r_dc_addr   <= '0;
         r_dc_wdata  <= '0;
         r_dc_be     <= '0;
         r_mis       <= 1'b0;
         r_to        <= 1'b0;
         r_alu_wb    <= '0;
         r_mem_wb    <= '0;
         r_pc4_wb    <= '0;
         r_wbsel_wb  <= '0;
         r_regwen_wb <= 1'b0;
         r_rsw_wb    <= '0;
         r_inst_wb   <= '0;
      end else begin
         r_mis <= w_mis;
         r_to  <= w_to;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state    <= S_WAIT;
                  r_cnt      <= '0;
                  r_f3       <= inst_mem_i[14:12];
                  r_off      <= alu_mem_i[1:0];
                  r_dc_we    <= MemRW_mem_i;
                  r_dc_addr  <= {alu_mem_i[31:2], 2'b00};
                  r_dc_wdata <= w_wdata;
                  r_dc_be    <= MemRW_mem_i ? w_be : 4'b1111;
               end
            end
            S_WAIT: begin
               if (dc_ack_i || w_to)
                  r_state <= S_IDLE;
               else
                  r_cnt <= r_cnt + CW'(1);
            end
         endcase
         if (w_adv) begin
            if (reset_i) begin
               r_alu_wb    <= '0;
               r_mem_wb    <= '0;
               r_pc4_wb    <= '0;
               r_wbsel_wb  <= '0;
               r_regwen_wb <= 1'b0;
               r_rsw_wb    <= '0;
               r_inst_wb   <= '0;
            end else begin
               r_alu_wb    <= alu_mem_i;
               r_pc4_wb    <= pc4_mem_i;
               r_wbsel_wb  <= WBSel_mem_i;
               r_regwen_wb <= RegWEn_mem_i & ~w_mis & ~w_to;
               r_rsw_wb    <= rsW_mem_i;
               r_inst_wb   <= inst_mem_i;
               if (w_ld_done)
                  r_mem_wb <= w_ldata;
            end
         end
      end
   end

   assign dc_req_o    = w_wait;
   assign dc_we_o     = r_dc_we;
   assign dc_addr_o   = r_dc_addr;
   assign dc_wdata_o  = r_dc_wdata;
   assign dc_be_o     = r_dc_be;
   assign stall_o     = w_stall;
   assign alu_wb_o    = r_alu_wb;
   assign mem_wb_o    = r_mem_wb;
   assign pc4_wb_o    = r_pc4_wb;
   assign WBSel_wb_o  = r_wbsel_wb;
   assign RegWEn_wb_o = r_regwen_wb;
   assign rsW_wb_o    = r_rsw_wb;
   assign inst_wb_o   = r_inst_wb;
   assign misalign_o  = r_mis;
   assign timeout_o   = r_to;

endmodule
